// File: rtl/fp_adder_seq_fsm.sv
// Multi-cycle floating-point adder/subtractor with pushbutton operand entry.
// Optional rounding: define FPADD_RNE_ROUND_EN for round-to-nearest-even, otherwise truncation.
module fp_adder_seq_fsm #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   button,
   input  logic                   switch,
   input  logic [EXP_W+MAN_W:0]   operand_in,
   output logic [EXP_W+MAN_W:0]   result,
   output logic [2:0]             state,
   output logic                   busy,
   output logic                   done,
   output logic                   ovf
);

   localparam int W = 1 + EXP_W + MAN_W;
   localparam int N = MAN_W + 4;
   localparam logic [EXP_W-1:0] EXP_MAX = '1;
   localparam logic [EXP_W-1:0] EXP_ONE = EXP_W'(1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD_B = 3'd1,
      S_ALIGN  = 3'd2,
      S_ADD    = 3'd3,
      S_NORM   = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   state_t           st;
   logic             btn_s1, btn_s2, btn_d;
   logic [W-1:0]     a_reg;
   logic             sa, sb, sgn;
   logic [EXP_W-1:0] ea, eb, ex;
   logic [N-1:0]     ma, mb;
   logic [N:0]       sum;

   logic             press;
   logic             a_small, far;
   logic [EXP_W-1:0] diff, ex_inc;
   logic [EXP_W-1:0] a_exp, b_exp;

   // Mantissa layout: hidden | fraction | guard | round | sticky; exp==0 flushes to zero.
   function automatic logic [N-1:0] unpack_man(input logic [W-1:0] v);
      if (v[W-2:MAN_W] == '0) return '0;
      return {1'b1, v[MAN_W-1:0], 3'b000};
   endfunction

   function automatic logic [N-1:0] shr_sticky(input logic [N-1:0] m);
      return {1'b0, m[N-1:2], m[1] | m[0]};
   endfunction

   function automatic logic [W-1:0] inf_val(input logic s);
      return {s, EXP_MAX, {MAN_W{1'b0}}};
   endfunction

`ifdef FPADD_RNE_ROUND_EN
   logic [MAN_W+1:0] rnd;

   // Returns {carry, hidden, fraction} after round-to-nearest-even.
   function automatic logic [MAN_W+1:0] round_rne(input logic [N-1:0] m);
      logic up;
      up = m[2] & (m[1] | m[0] | m[3]);
      return {1'b0, m[N-1:3]} + (MAN_W+2)'(up);
   endfunction
`endif

   assign press = btn_s2 & ~btn_d;
   assign state = st;
   assign a_exp = a_reg[W-2:MAN_W];
   assign b_exp = operand_in[W-2:MAN_W];

   always_comb begin
      a_small = (ea < eb);
      diff    = a_small ? (eb - ea) : (ea - eb);
      far     = (32'(diff) > 32'(MAN_W + 3));
      ex_inc  = ex + EXP_ONE;
`ifdef FPADD_RNE_ROUND_EN
      rnd     = round_rne(sum[N-1:0]);
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         st     <= S_IDLE;
         result <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         ovf    <= 1'b0;
         btn_s1 <= 1'b0;
         btn_s2 <= 1'b0;
         btn_d  <= 1'b0;
      end else begin
         btn_s1 <= button;
         btn_s2 <= btn_s1;
         btn_d  <= btn_s2;
         case (st)
            S_IDLE: begin
               if (press) begin
                  a_reg <= operand_in;
                  st    <= S_LOAD_B;
               end
            end
            S_LOAD_B: begin
               if (press) begin
                  if (a_exp == EXP_MAX) begin
                     result <= inf_val(a_reg[W-1]);
                     ovf    <= 1'b1;
                     done   <= 1'b1;
                     st     <= S_DONE;
                  end else if (b_exp == EXP_MAX) begin
                     result <= inf_val(operand_in[W-1]);
                     ovf    <= 1'b1;
                     done   <= 1'b1;
                     st     <= S_DONE;
                  end else begin
                     sa   <= a_reg[W-1];
                     sb   <= operand_in[W-1] ^ switch;
                     ea   <= a_exp;
                     eb   <= b_exp;
                     ma   <= unpack_man(a_reg);
                     mb   <= unpack_man(operand_in);
                     busy <= 1'b1;
                     st   <= S_ALIGN;
                  end
               end
            end
            S_ALIGN: begin
               if (ea == eb) begin
                  st <= S_ADD;
               end else if (a_small) begin
                  ma <= far ? N'(ma != '0) : shr_sticky(ma);
                  ea <= far ? eb : ea + EXP_ONE;
               end else begin
                  mb <= far ? N'(mb != '0) : shr_sticky(mb);
                  eb <= far ? ea : eb + EXP_ONE;
               end
            end
            S_ADD: begin
               if (sa == sb) begin
                  sum <= {1'b0, ma} + {1'b0, mb};
                  sgn <= sa;
               end else if (ma >= mb) begin
                  sum <= {1'b0, ma - mb};
                  sgn <= sa;
               end else begin
                  sum <= {1'b0, mb - ma};
                  sgn <= sb;
               end
               ex <= ea;
               st <= S_NORM;
            end
            S_NORM: begin
               if (sum == '0) begin
                  result <= '0;
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  st     <= S_DONE;
               end else if (sum[N]) begin
                  if (ex_inc == EXP_MAX) begin
                     result <= inf_val(sgn);
                     ovf    <= 1'b1;
                     busy   <= 1'b0;
                     done   <= 1'b1;
                     st     <= S_DONE;
                  end else begin
                     sum <= {1'b0, sum[N:2], sum[1] | sum[0]};
                     ex  <= ex_inc;
                  end
               end else if (sum[N-1]) begin
`ifdef FPADD_RNE_ROUND_EN
                  // A rounding carry leaves a zero fraction one binade up.
                  if (rnd[MAN_W+1] && ex_inc == EXP_MAX) begin
                     result <= inf_val(sgn);
                     ovf    <= 1'b1;
                  end else if (rnd[MAN_W+1]) begin
                     result <= {sgn, ex_inc, rnd[MAN_W-1:0]};
                  end else begin
                     result <= {sgn, ex, rnd[MAN_W-1:0]};
                  end
`else
                  result <= {sgn, ex, sum[N-2:3]};
`endif
                  busy <= 1'b0;
                  done <= 1'b1;
                  st   <= S_DONE;
               end else if (ex == EXP_ONE) begin
                  result <= {sgn, {(W-1){1'b0}}};
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  st     <= S_DONE;
               end else begin
                  sum <= {sum[N-1:0], 1'b0};
                  ex  <= ex - EXP_ONE;
               end
            end
            S_DONE: begin
               if (press) begin
                  done <= 1'b0;
                  ovf  <= 1'b0;
                  st   <= S_IDLE;
               end
            end
            default: st <= S_IDLE;
         endcase
      end
   end

endmodule
